// File: rtl/composite_video_encoder_if.sv
// ---------------------------------------------------------------------------
// composite_video_encoder_if
// Pixel-rate bundle between the video chip's pixel pipeline and the
// composite encoder.
//   luma         [3:0]  luminance level 0..15
//   chroma_phase [3:0]  hue angle, 16 steps of 22.5 deg
//   chroma_amp   [1:0]  saturation 0..3 (0 = no chroma)
//   sync                composite sync active
//   burst               colour-burst gate
//   line_start          one-clk pulse at start of each line
//   video        [5:0]  unsigned composite sample to the RF modulator
// master: pixel source (drives pixel fields, observes video)
// slave : encoder      (consumes pixel fields, drives video)
// ---------------------------------------------------------------------------
interface composite_video_encoder_if;
    logic [3:0] luma;
    logic [3:0] chroma_phase;
    logic [1:0] chroma_amp;
    logic       sync;
    logic       burst;
    logic       line_start;
    logic [5:0] video;

    modport master (
        output luma, chroma_phase, chroma_amp, sync, burst, line_start,
        input  video
    );

    modport slave (
        input  luma, chroma_phase, chroma_amp, sync, burst, line_start,
        output video
    );
endinterface

// File: rtl/composite_video_encoder.sv
// ---------------------------------------------------------------------------
// composite_video_encoder
// Builds the 6-bit composite baseband sample from per-pixel luma, chroma
// phase/amplitude, sync and burst. A free-running NCO provides the colour
// subcarrier phase; a 32-entry sine LUT modulates chroma; PAL V-switch
// alternation flips the chroma phase on every other line.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  asynchronous, active-high
//   vid    composite_video_encoder_if.slave (pixel fields in, video out)
// Pipeline: inputs -> video in exactly 3 clocks, all fields aligned.
// ---------------------------------------------------------------------------
module composite_video_encoder #(
    parameter logic [31:0] PHASE_INC   = 32'd114253485,
    parameter logic [5:0]  BLANK_LEVEL = 6'd16,
    parameter bit          PAL         = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    composite_video_encoder_if.slave   vid
);

    // round(15*sin(2*pi*k/32)); second half is the negated first half
    function automatic logic signed [4:0] sine_lut(input logic [4:0] k);
        logic signed [4:0] mag;
        case (k[3:0])
            4'd0:  mag = 5'sd0;
            4'd1:  mag = 5'sd3;
            4'd2:  mag = 5'sd6;
            4'd3:  mag = 5'sd8;
            4'd4:  mag = 5'sd11;
            4'd5:  mag = 5'sd12;
            4'd6:  mag = 5'sd14;
            4'd7:  mag = 5'sd15;
            4'd8:  mag = 5'sd15;
            4'd9:  mag = 5'sd15;
            4'd10: mag = 5'sd14;
            4'd11: mag = 5'sd12;
            4'd12: mag = 5'sd11;
            4'd13: mag = 5'sd8;
            4'd14: mag = 5'sd6;
            default: mag = 5'sd3;
        endcase
        return k[4] ? -mag : mag;
    endfunction

    logic [31:0]       acc_q;
    logic              vswitch_q;

    // stage 1
    logic [4:0]        s1_addr_q, s1_addr_d;
    logic [1:0]        s1_amp_q, s1_amp_d;
    logic [3:0]        s1_luma_q, s1_luma_d;
    logic              s1_sync_q;
    logic [4:0]        off;

    // stage 2
    logic signed [6:0] s2_term_q, s2_term_d;
    logic [3:0]        s2_luma_q;
    logic              s2_sync_q;
    logic signed [6:0] sine_ext, amp_ext, prod;

    // stage 3
    logic [5:0]        video_q, video_d;
    logic signed [7:0] blank_s, luma2_s, term_s, sum;

    always_comb begin
        off = {vid.chroma_phase, 1'b0};
        if (PAL && vswitch_q) off = 5'd0 - off;
        s1_amp_d  = vid.chroma_amp;
        s1_luma_d = vid.luma;
        if (vid.burst) begin
            // burst at 180 deg (NTSC) or 135/225 deg alternating (PAL)
            off       = PAL ? (vswitch_q ? 5'd20 : 5'd12) : 5'd16;
            s1_amp_d  = 2'd2;
            s1_luma_d = '0;
        end
        s1_addr_d = acc_q[31:27] + off;
    end

    always_comb begin
        sine_ext  = {{2{sine_lut(s1_addr_q)[4]}}, sine_lut(s1_addr_q)};
        amp_ext   = {5'b0, s1_amp_q};
        prod      = sine_ext * amp_ext;
        s2_term_d = prod >>> 2;
    end

    always_comb begin
        blank_s = {2'b00, BLANK_LEVEL};
        luma2_s = {3'b000, s2_luma_q, 1'b0};
        term_s  = {s2_term_q[6], s2_term_q};
        sum     = blank_s + luma2_s + term_s;
        // code 0 is reserved for the sync tip
        if (s2_sync_q)         video_d = '0;
        else if (sum < 8'sd1)  video_d = 6'd1;
        else if (sum > 8'sd63) video_d = 6'd63;
        else                   video_d = sum[5:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            vswitch_q <= 1'b0;
            s1_addr_q <= '0;
            s1_amp_q  <= '0;
            s1_luma_q <= '0;
            s1_sync_q <= 1'b0;
            s2_term_q <= '0;
            s2_luma_q <= '0;
            s2_sync_q <= 1'b0;
            video_q   <= BLANK_LEVEL;
        end else begin
            acc_q <= acc_q + PHASE_INC;
            if (PAL && vid.line_start) vswitch_q <= ~vswitch_q;
            s1_addr_q <= s1_addr_d;
            s1_amp_q  <= s1_amp_d;
            s1_luma_q <= s1_luma_d;
            s1_sync_q <= vid.sync;
            s2_term_q <= s2_term_d;
            s2_luma_q <= s1_luma_q;
            s2_sync_q <= s1_sync_q;
            video_q   <= video_d;
        end
    end

    assign vid.video = video_q;

endmodule

// File: tb/tb_composite_video_encoder.sv
// Four encoder instances share one stimulus stream:
//   0: defaults, 1: inc 0x0800_0000 PAL, 2: inc 0x0800_0000 NTSC, 3: BLANK 60
module tb_composite_video_encoder;

    localparam int NI = 4;
    localparam logic [31:0] INC_T [NI] = '{32'd114253485, 32'h0800_0000, 32'h0800_0000, 32'd114253485};
    localparam bit          PAL_T [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};
    localparam int          BLK_T [NI] = '{16, 16, 16, 60};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] luma, phase;
    logic [1:0] amp;
    logic       sync, burst, ls;
    logic [5:0] vid [NI];

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    composite_video_encoder_if bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_drv
        assign bus[g].luma         = luma;
        assign bus[g].chroma_phase = phase;
        assign bus[g].chroma_amp   = amp;
        assign bus[g].sync         = sync;
        assign bus[g].burst        = burst;
        assign bus[g].line_start   = ls;
        assign vid[g]              = bus[g].video;
    end

    composite_video_encoder dut0 (.clk(clk), .reset(reset), .vid(bus[0]));
    composite_video_encoder #(.PHASE_INC(32'h0800_0000), .PAL(1'b1)) dut1 (.clk(clk), .reset(reset), .vid(bus[1]));
    composite_video_encoder #(.PHASE_INC(32'h0800_0000), .PAL(1'b0)) dut2 (.clk(clk), .reset(reset), .vid(bus[2]));
    composite_video_encoder #(.BLANK_LEVEL(6'd60)) dut3 (.clk(clk), .reset(reset), .vid(bus[3]));

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Composite sample for one pixel, straight from the encoding rules.
    function automatic int model(input int blank, input bit pal, input int top, input bit vs,
                                 input int l, input int ph, input int a, input bit sy, input bit bu);
        int  k, idx, s, t, term, sum;
        real r;
        if (sy) return 0;
        if (bu) begin
            k = pal ? (vs ? 20 : 12) : 16;
            a = 2;
            l = 0;
        end else begin
            k = 2 * ph;
            if (pal && vs) k = (32 - k) % 32;
        end
        idx = (top + k) % 32;
        r = 15.0 * $sin(2.0 * 3.14159265358979 * idx / 32.0);
        s = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        t = s * a;
        term = (t >= 0) ? t / 4 : -((3 - t) / 4);
        sum = blank + 2 * l + term;
        if (sum < 1) sum = 1;
        if (sum > 63) sum = 63;
        return sum;
    endfunction

    // Reference: pixel n (counted from reset release) sees NCO phase n*INC
    // and V-switch = parity of line_starts seen before it; output shows
    // the value of the pixel taken three edges earlier.
    int  pipe [NI][3];
    bit  vsm  [NI];
    int  n;

    initial begin
        n = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (reset) begin
                    for (int j = 0; j < 3; j++) pipe[i][j] = BLK_T[i];
                    vsm[i] = 1'b0;
                end else begin
                    logic [31:0] a;
                    a = 32'(n) * INC_T[i];
                    pipe[i][2] = pipe[i][1];
                    pipe[i][1] = pipe[i][0];
                    pipe[i][0] = model(BLK_T[i], PAL_T[i], int'(a[31:27]), vsm[i],
                                       int'(luma), int'(phase), int'(amp), sync, burst);
                    if (PAL_T[i] && ls) vsm[i] = ~vsm[i];
                end
            end
            n = reset ? 0 : n + 1;
            #1;
            for (int i = 0; i < NI; i++) check($sformatf("model_dut%0d", i), int'(vid[i]), pipe[i][2]);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int mx, mn, p;
        reset = 1'b1; luma = '0; phase = '0; amp = '0; sync = 1'b0; burst = 1'b0; ls = 1'b0;
        repeat (3) step();
        for (int i = 0; i < NI; i++) check("reset_state", int'(vid[i]), BLK_T[i]);

        // subcarrier sweep, inc 0x0800_0000
        amp = 2'd3;
        reset = 1'b0;
        repeat (3) step();
        check("sweep_first", int'(vid[1]), 16);
        step();
        check("sweep_second", int'(vid[1]), 18);
        mx = 0; mn = 63;
        repeat (32) begin
            step();
            if (int'(vid[1]) > mx) mx = int'(vid[1]);
            if (int'(vid[1]) < mn) mn = int'(vid[1]);
        end
        check("sweep_max", mx, 27);
        check("sweep_min", mn, 4);

        // asynchronous reset mid-run
        luma = 4'd9;
        repeat (6) step();
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) check("async_reset", int'(vid[i]), BLK_T[i]);
        repeat (2) step();

        // flat luma, then sync+burst pulse
        luma = 4'd15; amp = 2'd0; reset = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 8; k++) begin
            check("flat_luma", int'(vid[0]), 46);
            check("flat_clamp", int'(vid[3]), 63);
            step();
        end
        sync = 1'b1; burst = 1'b1;
        repeat (2) step();
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 2) begin sync = 1'b0; burst = 1'b0; end
            for (int i = 0; i < NI; i++) check("sync_pulse", int'(vid[i]), 0);
        end
        step();
        check("sync_end", int'(vid[0]), 46);

        // burst lines with line_start every 32 clocks
        reset = 1'b1;
        step();
        reset = 1'b0; burst = 1'b1; luma = 4'd5; amp = 2'd1; phase = 4'd7;
        for (int k = 0; k < 131; k++) begin
            ls = (k % 32 == 0);
            step();
            if (k >= 2 && (k - 2) % 32 == 0) begin
                p = k - 2;
                check("pal_burst", int'(vid[1]), ((p / 32) % 2 == 1) ? 10 : 21);
                check("ntsc_burst", int'(vid[2]), 16);
            end
        end
        ls = 1'b0; burst = 1'b0;

        // randomized pixels
        for (int k = 0; k < 3000; k++) begin
            luma  = 4'($urandom_range(0, 15));
            phase = 4'($urandom_range(0, 15));
            amp   = 2'($urandom_range(0, 3));
            sync  = ($urandom_range(0, 7) == 0);
            burst = ($urandom_range(0, 7) == 0);
            ls    = ($urandom_range(0, 15) == 0);
            step();
        end
        ls = 1'b0; sync = 1'b0; burst = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
